// File: rtl/alu32_cmd_ctrl_if.sv
// alu32_cmd_ctrl_if: command, ALU and response channels of alu32_cmd_ctrl.
// Optional flag outputs exist only when ALU_FLAGS_EN is defined.
interface alu32_cmd_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_sel;
  logic [31:0] alu_y;
  logic        alu_cout;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_y;
  logic        rsp_cout;
  logic        rsp_err;
`ifdef ALU_FLAGS_EN
  logic        rsp_zero;
  logic        rsp_neg;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b,
    output cmd_ready,
    output alu_a, alu_b, alu_sel,
    input  alu_y, alu_cout,
    output rsp_valid, rsp_y, rsp_cout, rsp_err,
    output rsp_zero, rsp_neg,
    input  rsp_ready
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b,
    input  cmd_ready,
    input  alu_a, alu_b, alu_sel,
    output alu_y, alu_cout,
    input  rsp_valid, rsp_y, rsp_cout, rsp_err,
    input  rsp_zero, rsp_neg,
    output rsp_ready
  );
`else
  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b,
    output cmd_ready,
    output alu_a, alu_b, alu_sel,
    input  alu_y, alu_cout,
    output rsp_valid, rsp_y, rsp_cout, rsp_err,
    input  rsp_ready
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b,
    input  cmd_ready,
    input  alu_a, alu_b, alu_sel,
    output alu_y, alu_cout,
    input  rsp_valid, rsp_y, rsp_cout, rsp_err,
    output rsp_ready
  );
`endif
endinterface

// File: rtl/alu32_cmd_ctrl.sv
// alu32_cmd_ctrl: command FIFO + issue FSM in front of the 32-bit ALU.
// Define ALU_FLAGS_EN to add captured rsp_zero/rsp_neg flags.
module alu32_cmd_ctrl #(
  parameter int CMD_DEPTH = 4,
  parameter int PTR_W     = 2
) (
  input  logic             clk,
  input  logic             rst,
  alu32_cmd_ctrl_if.slave  bus,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    EXEC,
    RESP
  } state_t;

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(CMD_DEPTH);

  state_t state;

  logic [31:0]      mem_a  [CMD_DEPTH];
  logic [31:0]      mem_b  [CMD_DEPTH];
  logic [3:0]       mem_op [CMD_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic illegal;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign push    = bus.cmd_valid && !full;
  assign pop     = !empty &&
                   ((state == IDLE) ||
                    (state == RESP && bus.rsp_ready));
  assign illegal = (bus.alu_sel > 4'd9);

  assign bus.cmd_ready = !full;
  assign busy          = !empty || (state != IDLE);

  // Command storage; contents need no reset since count gates reads.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr]  <= bus.cmd_a;
      mem_b[wr_ptr]  <= bus.cmd_b;
      mem_op[wr_ptr] <= bus.cmd_op;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Issue/capture FSM with registered ALU operands and response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bus.alu_a     <= '0;
      bus.alu_b     <= '0;
      bus.alu_sel   <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_y     <= '0;
      bus.rsp_cout  <= 1'b0;
      bus.rsp_err   <= 1'b0;
`ifdef ALU_FLAGS_EN
      bus.rsp_zero  <= 1'b0;
      bus.rsp_neg   <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (pop) begin
            bus.alu_a   <= mem_a[rd_ptr];
            bus.alu_b   <= mem_b[rd_ptr];
            bus.alu_sel <= mem_op[rd_ptr];
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          state <= EXEC;
        end
        EXEC: begin
          bus.rsp_valid <= 1'b1;
          bus.rsp_err   <= illegal;
          bus.rsp_y     <= illegal ? 32'd0 : bus.alu_y;
          bus.rsp_cout  <= illegal ? 1'b0 : bus.alu_cout;
`ifdef ALU_FLAGS_EN
          bus.rsp_zero  <= !illegal && (bus.alu_y == 32'd0);
          bus.rsp_neg   <= !illegal && bus.alu_y[31];
`endif
          state         <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            if (pop) begin
              bus.alu_a   <= mem_a[rd_ptr];
              bus.alu_b   <= mem_b[rd_ptr];
              bus.alu_sel <= mem_op[rd_ptr];
              state       <= ISSUE;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu32_cmd_ctrl.sv
// tb_alu32_cmd_ctrl: random + directed bench with an in-order response model.
// Build with ALU_FLAGS_EN to also check rsp_zero/rsp_neg.
module tb_alu32_cmd_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;

  alu32_cmd_ctrl_if bus();

  alu32_cmd_ctrl #(.CMD_DEPTH(4), .PTR_W(2)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] y;
    logic        cout;
    logic        err;
    logic        zero;
    logic        neg;
  } rsp_t;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // ALU behaviour: {cout, y}. Illegal opcodes produce garbage on purpose.
  function automatic logic [32:0] alu_fn(input logic [3:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    logic [32:0] r;
    case (op)
      4'h0: r = {1'b0, a} + {1'b0, b};
      4'h1: r = {(a < b), a - b};
      4'h2: r = {1'b0, a} + 33'd1;
      4'h3: r = {(a == 32'd0), a - 32'd1};
      4'h4: r = {1'b0, a & b};
      4'h5: r = {1'b0, a | b};
      4'h6: r = {1'b0, a ^ b};
      4'h7: r = {1'b0, ~a};
      4'h8: r = {1'b0, a << 1};
      4'h9: r = {1'b0, a >> 1};
      default: r = {1'b1, a ^ b ^ 32'h5A5A_0001};
    endcase
    return r;
  endfunction

  always_comb {bus.alu_cout, bus.alu_y} = alu_fn(bus.alu_sel, bus.alu_a, bus.alu_b);

  function automatic rsp_t expect_rsp(input logic [3:0] op,
                                      input logic [31:0] a,
                                      input logic [31:0] b);
    rsp_t r;
    logic [32:0] v;
    r = '0;
    if (op > 4'd9) begin
      r.err = 1'b1;
    end else begin
      v      = alu_fn(op, a, b);
      r.y    = v[31:0];
      r.cout = v[32];
`ifdef ALU_FLAGS_EN
      r.zero = (v[31:0] == 32'd0);
      r.neg  = v[31];
`endif
    end
    return r;
  endfunction

  function automatic rsp_t cur_rsp();
    rsp_t r;
    r      = '0;
    r.y    = bus.rsp_y;
    r.cout = bus.rsp_cout;
    r.err  = bus.rsp_err;
`ifdef ALU_FLAGS_EN
    r.zero = bus.rsp_zero;
    r.neg  = bus.rsp_neg;
`endif
    return r;
  endfunction

  rsp_t exp_q[$];
  rsp_t obs_q[$];
  bit   seen_rst  = 1'b0;
  bit   prev_hold = 1'b0;
  rsp_t prev_rsp;

  // Compare process: sampled mid-cycle, predicts the coming edge.
  always @(negedge clk) begin
    rsp_t c;
    rsp_t e;
    if (rst) begin
      exp_q.delete();
      prev_hold = 1'b0;
      seen_rst  = 1'b1;
    end else if (seen_rst) begin
      c = cur_rsp();
      chk("busy", busy, exp_q.size() != 0);
      if (prev_hold) begin
        chk("hold_valid", bus.rsp_valid, 1);
        chk("hold_data", c, prev_rsp);
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        chk("rsp_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("rsp_data", c, e);
        end
        obs_q.push_back(c);
      end
      if (bus.cmd_valid && bus.cmd_ready)
        exp_q.push_back(expect_rsp(bus.cmd_op, bus.cmd_a, bus.cmd_b));
      prev_hold = bus.rsp_valid && !bus.rsp_ready;
      prev_rsp  = c;
    end
  end

  task automatic send(input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input int max_cyc,
                      output bit ok);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    ok = 1'b0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      @(negedge clk);
      ok = bus.cmd_ready;
      @(posedge clk);
      #1;
    end
    bus.cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_alu_a", bus.alu_a, 0);
    chk("rst_alu_b", bus.alu_b, 0);
    chk("rst_alu_sel", bus.alu_sel, 0);
    chk("rst_rsp", cur_rsp(), 0);
    obs_q.delete();
  endtask

  task automatic drain(input int max_cyc);
    bit done;
    done = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < max_cyc && !done; i++) begin
      @(negedge clk);
      done = !busy && !bus.rsp_valid;
      @(posedge clk);
      #1;
    end
    chk("drain_done", done, 1);
  endtask

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h0000_0001;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    bit   ok;
    int   lat;
    int   nacc;
    bit   rnd_done;
    rsp_t m;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.rsp_ready = 1'b0;

    // Model pins.
    m = expect_rsp(4'h0, 32'hFFFF_FFFF, 32'h1);
    chk("pin_add", {m.y, m.cout, m.err}, {32'h0, 1'b1, 1'b0});
    m = expect_rsp(4'h1, 32'h5, 32'h7);
    chk("pin_sub", {m.y, m.cout}, {32'hFFFF_FFFE, 1'b1});
    m = expect_rsp(4'hC, 32'h1234_5678, 32'h0);
    chk("pin_illegal", {m.y, m.cout, m.err}, {32'h0, 1'b0, 1'b1});

    // 1: ADD carry-out and latency.
    do_reset();
    send(4'h0, 32'hFFFF_FFFF, 32'h1, 4, ok);
    chk("t1_accept", ok, 1);
    lat = 0;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      if (bus.rsp_valid) lat = i - 1;
      else begin
        @(posedge clk);
        #1;
        if (bus.rsp_valid) lat = i;
      end
    end
    chk("t1_latency", lat, 3);
    chk("t1_rsp", {bus.rsp_y, bus.rsp_cout, bus.rsp_err}, {32'h0, 1'b1, 1'b0});
    drain(20);

    // 2: SUB then DEC back to back, in order.
    obs_q.delete();
    bus.rsp_ready = 1'b1;
    send(4'h1, 32'h5, 32'h7, 4, ok);
    send(4'h3, 32'h0, 32'h0, 4, ok);
    drain(30);
    chk("t2_count", obs_q.size(), 2);
    if (obs_q.size() == 2) begin
      chk("t2_first", {obs_q[0].y, obs_q[0].cout}, {32'hFFFF_FFFE, 1'b1});
      chk("t2_second", {obs_q[1].y, obs_q[1].cout}, {32'hFFFF_FFFF, 1'b1});
    end

    // 3: backpressure fills the FIFO.
    obs_q.delete();
    bus.rsp_ready = 1'b0;
    nacc = 0;
    for (int i = 0; i < 6; i++) begin
      send(4'h0, 32'(i), 32'd100, 3, ok);
      if (ok) nacc++;
    end
    chk("t3_accepted", nacc, 5);
    chk("t3_cmd_ready", bus.cmd_ready, 0);
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    drain(60);
    chk("t3_count", obs_q.size(), 5);
    for (int i = 0; i < 5 && i < obs_q.size(); i++)
      chk("t3_order", obs_q[i].y, 32'(100 + i));

    // 4: illegal opcode forced to zero, then XOR.
    obs_q.delete();
    send(4'hC, 32'h1234_5678, 32'hFFFF_0000, 4, ok);
    send(4'h6, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 8, ok);
    drain(30);
    chk("t4_count", obs_q.size(), 2);
    if (obs_q.size() == 2) begin
      chk("t4_illegal", {obs_q[0].y, obs_q[0].cout, obs_q[0].err},
          {32'h0, 1'b0, 1'b1});
      chk("t4_xor", {obs_q[1].y, obs_q[1].err}, {32'hFFFF_FFFF, 1'b0});
    end

    // 5: reset in RESP with two queued.
    bus.rsp_ready = 1'b0;
    send(4'h2, 32'h1, 32'h0, 4, ok);
    send(4'h2, 32'h2, 32'h0, 4, ok);
    send(4'h2, 32'h3, 32'h0, 4, ok);
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      ok = bus.rsp_valid;
      @(posedge clk);
      #1;
    end
    chk("t5_in_resp", ok, 1);
    do_reset();
    bus.rsp_ready = 1'b1;
    repeat (12) begin
      @(posedge clk);
      #1;
    end
    chk("t5_no_stale", obs_q.size(), 0);

`ifdef ALU_FLAGS_EN
    // 6: flags.
    obs_q.delete();
    send(4'h8, 32'h8000_0000, 32'h0, 4, ok);
    send(4'h7, 32'h0, 32'h0, 8, ok);
    drain(30);
    chk("t6_count", obs_q.size(), 2);
    if (obs_q.size() == 2) begin
      chk("t6_shl", {obs_q[0].y, obs_q[0].zero, obs_q[0].neg},
          {32'h0, 1'b1, 1'b0});
      chk("t6_not", {obs_q[1].y, obs_q[1].zero, obs_q[1].neg},
          {32'hFFFF_FFFF, 1'b0, 1'b1});
    end
`endif

    // Random traffic with random backpressure.
    rnd_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 400; n++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          send(4'($urandom_range(0, 15)), pick32(), pick32(), 60, ok);
          if (!ok) chk("rnd_send", ok, 1);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          bus.rsp_ready = ($urandom_range(0, 9) < 7);
        end
      end
    join
    drain(100);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
